// File: rtl/ftoi_arbiter_if.sv
// Request/response bundle between the requesters, the shared ftoi arbiter and the result consumer.
interface ftoi_arbiter_if #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
);
  logic [NREQ-1:0]      req_valid;
  logic [32*NREQ-1:0]   req_x;
  logic [NREQ-1:0]      req_ready;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [IDW-1:0]       resp_id;
  logic [31:0]          resp_data;
  logic                 busy;

  modport master (
    output req_valid, req_x, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data, busy
  );

  modport slave (
    input  req_valid, req_x, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data, busy
  );
endinterface

// File: rtl/ftoi_arbiter.sv
// Round-robin share of one fixed-latency float-to-int converter with an in-order,
// credit-gated response FIFO so that a stalled consumer never loses a result.
module ftoi_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1,
  parameter int DEPTH = 4,
  parameter int LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  ftoi_arbiter_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]             cnt;
  logic [IDW-1:0]            ptr;
  logic [LAT-1:0]            vld;
  logic [LAT-1:0][IDW-1:0]   ids;
  logic [LAT-1:0][31:0]      dat;
  logic [PW-1:0]             wptr, rptr;
  logic [CW-1:0]             fcnt;
  logic [IDW-1:0]            mem_id  [DEPTH];
  logic [31:0]               mem_dat [DEPTH];

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gsel;
  logic [31:0]     x_in;
  logic            found;
  logic            pop;
  logic            wr;

  // Truncating conversion; shifts for huge exponents wrap mod 32 by design.
  function automatic logic [31:0] ftoi(input logic [31:0] x);
    logic [7:0]  e;
    logic [7:0]  sh;
    logic [31:0] m;
    logic [31:0] mag;
    e   = x[30:23];
    m   = {8'd0, 1'b1, x[22:0]};
    sh  = '0;
    mag = '0;
    if (e < 8'd127) begin
      mag = '0;
    end else if (e >= 8'd150) begin
      sh  = e - 8'd150;
      mag = m << sh[4:0];
    end else begin
      sh  = 8'd150 - e;
      mag = m >> sh[4:0];
    end
    return x[31] ? -mag : mag;
  endfunction

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    int unsigned idx;
    logic [IDW-1:0] sel;
    grant = '0;
    gsel  = '0;
    x_in  = '0;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    if (cnt < CW'(DEPTH)) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        idx = 32'(ptr) + k;
        if (idx >= unsigned'(NREQ)) idx = idx - unsigned'(NREQ);
        sel = IDW'(idx);
        if (!found && bus.req_valid[sel]) begin
          found      = 1'b1;
          grant[sel] = 1'b1;
          gsel       = sel;
          x_in       = bus.req_x[32*sel +: 32];
        end
      end
    end
  end

  assign bus.req_ready  = grant;
  assign bus.resp_valid = (fcnt != '0);
  assign bus.resp_id    = bus.resp_valid ? mem_id[rptr]  : '0;
  assign bus.resp_data  = bus.resp_valid ? mem_dat[rptr] : '0;
  assign bus.busy       = (cnt != '0);

  assign pop = bus.resp_valid & bus.resp_ready;
  assign wr  = vld[LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      ptr  <= '0;
      vld  <= '0;
      ids  <= '0;
      dat  <= '0;
      wptr <= '0;
      rptr <= '0;
      fcnt <= '0;
    end else begin
      case ({found, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (found) ptr <= (gsel == IDW'(NREQ - 1)) ? '0 : gsel + 1'b1;

      // Converted value rides alongside its tag; equivalent to an LAT-deep ftoi core.
      vld[0] <= found;
      ids[0] <= gsel;
      dat[0] <= ftoi(x_in);
      for (int unsigned s = 1; s < LAT; s++) begin
        vld[s] <= vld[s-1];
        ids[s] <= ids[s-1];
        dat[s] <= dat[s-1];
      end

      if (wr)  wptr <= nxt(wptr);
      if (pop) rptr <= nxt(rptr);
      case ({wr, pop})
        2'b10:   fcnt <= fcnt + 1'b1;
        2'b01:   fcnt <= fcnt - 1'b1;
        default: fcnt <= fcnt;
      endcase
      assert (!(wr && !pop && fcnt == CW'(DEPTH)));
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem_id[wptr]  <= ids[LAT-1];
      mem_dat[wptr] <= dat[LAT-1];
    end
  end
endmodule

// File: tb/tb_ftoi_arbiter.sv
// Bench for ftoi_arbiter: directed vector table, corner-case sequences and random traffic vs a queue model.
module tb_ftoi_arbiter;
  localparam int NREQ = 2, IDW = 1, DEPTH = 4, LAT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ftoi_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();
  ftoi_arbiter #(.NREQ(NREQ), .IDW(IDW), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int vectors = 0, miscompares = 0;

  typedef struct { int id; logic [31:0] data; int vis; } op_t;
  op_t inflight[$];
  op_t fifo_q[$];
  int  m_ptr = 0;
  int  cyc = 0;

  typedef struct {
    logic [1:0] rv; logic [31:0] x0; logic [31:0] x1; logic rr;
    logic [1:0] ready; logic rvalid; logic id; logic [31:0] data; logic busy;
  } vec_t;
  vec_t tbl[12];

  logic [1:0]     g;
  logic           v, b;
  logic [IDW-1:0] id;
  logic [31:0]    d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_conv(input logic [31:0] x);
    int  e;
    int  r;
    real mag;
    e = int'(x[30:23]);
    if (e < 127) return '0;
    mag = (8388608.0 + real'(x[22:0])) * (2.0 ** (e - 150));
    r = $rtoi(mag);
    if (x[31]) r = -r;
    return r;
  endfunction

  function automatic logic [31:0] rand_float();
    logic [7:0] e;
    e = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(126, 0)) : 8'($urandom_range(157, 127));
    return {1'($urandom_range(1, 0)), e, 23'($urandom)};
  endfunction

  // One clock cycle: drive, sample mid-cycle, compare with the model, advance the model.
  task automatic step(input logic [1:0] rv, input logic [31:0] x0, input logic [31:0] x1,
                      input logic rr, output logic [1:0] go, output logic vo,
                      output logic [IDW-1:0] ido, output logic [31:0] do_, output logic bo);
    logic [1:0] eg;
    logic       hit;
    int         n;
    op_t        op;
    bus.req_valid  = rv;
    bus.req_x      = {x1, x0};
    bus.resp_ready = rr;
    #3;
    eg  = '0;
    hit = 1'b0;
    if (inflight.size() + fifo_q.size() < DEPTH)
      for (int k = 0; k < NREQ; k++) begin
        n = (m_ptr + k) % NREQ;
        if (!hit && rv[n]) begin eg[n] = 1'b1; hit = 1'b1; end
      end
    chk("req_ready", 32'(bus.req_ready), 32'(eg));
    chk("resp_valid", 32'(bus.resp_valid), 32'(fifo_q.size() > 0));
    if (fifo_q.size() > 0) begin
      chk("resp_id", 32'(bus.resp_id), 32'(fifo_q[0].id));
      chk("resp_data", bus.resp_data, fifo_q[0].data);
    end else begin
      chk("resp_id_empty", 32'(bus.resp_id), 32'd0);
      chk("resp_data_empty", bus.resp_data, 32'd0);
    end
    chk("busy", 32'(bus.busy), 32'((inflight.size() + fifo_q.size()) != 0));
    go = bus.req_ready; vo = bus.resp_valid; ido = bus.resp_id; do_ = bus.resp_data; bo = bus.busy;
    if (rr && fifo_q.size() > 0) void'(fifo_q.pop_front());
    for (int k = 0; k < NREQ; k++)
      if (eg[k]) begin
        op.id = k; op.data = ref_conv(k == 1 ? x1 : x0); op.vis = cyc + LAT + 1;
        inflight.push_back(op);
        m_ptr = (k + 1) % NREQ;
      end
    cyc++;
    while (inflight.size() > 0 && inflight[0].vis <= cyc) fifo_q.push_back(inflight.pop_front());
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (inflight.size() + fifo_q.size()) > 0; i++)
      step(2'b00, '0, '0, 1'b1, g, v, id, d, b);
    #3;
    chk("drain_idle", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int acc, cntv;
    tbl[0]  = '{2'b01, 32'h3F800000, 32'h0,        1'b1, 2'b01, 1'b0, 1'b0, 32'h0,        1'b0};
    tbl[1]  = '{2'b00, 32'h0,        32'h0,        1'b1, 2'b00, 1'b0, 1'b0, 32'h0,        1'b1};
    tbl[2]  = '{2'b00, 32'h0,        32'h0,        1'b1, 2'b00, 1'b0, 1'b0, 32'h0,        1'b1};
    tbl[3]  = '{2'b00, 32'h0,        32'h0,        1'b1, 2'b00, 1'b1, 1'b0, 32'h1,        1'b1};
    tbl[4]  = '{2'b00, 32'h0,        32'h0,        1'b1, 2'b00, 1'b0, 1'b0, 32'h0,        1'b0};
    tbl[5]  = '{2'b10, 32'h0,        32'hC0200000, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0,        1'b0};
    tbl[6]  = '{2'b10, 32'h0,        32'h3F000000, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0,        1'b1};
    tbl[7]  = '{2'b10, 32'h0,        32'h42C98000, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0,        1'b1};
    tbl[8]  = '{2'b00, 32'h0,        32'h0,        1'b1, 2'b00, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b1};
    tbl[9]  = '{2'b00, 32'h0,        32'h0,        1'b1, 2'b00, 1'b1, 1'b1, 32'h0,        1'b1};
    tbl[10] = '{2'b00, 32'h0,        32'h0,        1'b1, 2'b00, 1'b1, 1'b1, 32'h64,       1'b1};
    tbl[11] = '{2'b00, 32'h0,        32'h0,        1'b1, 2'b00, 1'b0, 1'b0, 32'h0,        1'b0};

    rst = 1'b1;
    bus.req_valid = '0; bus.req_x = '0; bus.resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_id", 32'(bus.resp_id), 32'd0);
    chk("rst_resp_data", bus.resp_data, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rv, tbl[i].x0, tbl[i].x1, tbl[i].rr, g, v, id, d, b);
      chk("tbl_ready", 32'(g), 32'(tbl[i].ready));
      chk("tbl_rvalid", 32'(v), 32'(tbl[i].rvalid));
      chk("tbl_id", 32'(id), 32'(tbl[i].id));
      chk("tbl_data", d, tbl[i].data);
      chk("tbl_busy", 32'(b), 32'(tbl[i].busy));
    end

    for (int k = 0; k < 10; k++) begin
      step(2'b11, rand_float(), rand_float(), 1'b1, g, v, id, d, b);
      chk("fair_grant", 32'(g), (k % 2 == 0) ? 32'd1 : 32'd2);
    end
    drain();

    acc = 0;
    for (int k = 0; k < 8; k++) begin
      step(2'b11, rand_float(), rand_float(), 1'b0, g, v, id, d, b);
      if (g != '0) acc++;
    end
    chk("bp_accepts", 32'(acc), 32'd4);
    chk("bp_ready_held", 32'(g), 32'd0);
    step(2'b11, rand_float(), rand_float(), 1'b1, g, v, id, d, b);
    chk("bp_no_bypass", 32'(g), 32'd0);
    step(2'b11, rand_float(), rand_float(), 1'b0, g, v, id, d, b);
    chk("bp_regrant", 32'($onehot(g)), 32'd1);
    step(2'b11, rand_float(), rand_float(), 1'b0, g, v, id, d, b);
    chk("bp_full_again", 32'(g), 32'd0);
    drain();

    // Occupancy 3 with a write and a pop landing on the same edge.
    for (int k = 0; k < 4; k++) step(2'b01, 32'h3F800000 + 32'(k) * 32'h00800000, '0, 1'b0, g, v, id, d, b);
    step(2'b00, '0, '0, 1'b0, g, v, id, d, b);
    step(2'b00, '0, '0, 1'b1, g, v, id, d, b);
    cntv = 0;
    for (int i = 0; i < 10; i++) begin
      step(2'b00, '0, '0, 1'b1, g, v, id, d, b);
      if (v) cntv++;
    end
    chk("occ3_remaining", 32'(cntv), 32'd3);

    for (int k = 0; k < 4; k++) step(2'b01, rand_float(), '0, 1'b0, g, v, id, d, b);
    bus.req_valid = '0;
    rst = 1'b1;
    #1;
    chk("async_rst_rvalid", 32'(bus.resp_valid), 32'd0);
    chk("async_rst_id", 32'(bus.resp_id), 32'd0);
    chk("async_rst_data", bus.resp_data, 32'd0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    inflight.delete(); fifo_q.delete(); m_ptr = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(2'b11, rand_float(), rand_float(), 1'b1, g, v, id, d, b);
      if (k == 0) chk("post_rst_first_grant", 32'(g), 32'd1);
    end
    drain();

    for (int k = 0; k < 300; k++)
      step(2'($urandom_range(3, 0)), rand_float(), rand_float(), ($urandom_range(9, 0) < 6),
           g, v, id, d, b);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
